// File: rtl/rs232_pkg.sv
// Shared constants for the RS-232 transmit path: byte width, ASCII control codes
// and the drain-FSM state encoding used by rs232out_fifo.
package rs232_pkg;

  localparam int RS232_WIDTH = 8;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic IDLE = 1'b0;
  localparam logic HOLD = 1'b1;

  typedef enum logic {
    ST_IDLE = IDLE,
    ST_HOLD = HOLD
  } drain_state_e;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage with one synchronous write port and one asynchronous read
// port, so it maps onto distributed RAM.
module fifo_ram #(
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rs232out_fifo.sv
// Transmit FIFO in front of the serial transmitter; drains one byte per character.
// Optional macro RS232OUT_FIFO_CRLF_EN expands each queued LF into CR,LF on the wire.
module rs232out_fifo
  import rs232_pkg::*;
#(
  parameter int LOG2_DEPTH = 4,
  parameter int WIDTH      = RS232_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                wr_en,
  output logic                full,
  output logic                empty,
  output logic [LOG2_DEPTH:0] level,
  output logic                overflow,
  output logic [WIDTH-1:0]    tx_data,
  output logic                tx_we,
  input  logic                tx_busy,
  output drain_state_e        dbg_state
);

  // Handshake to the transmitter: tx_we is a one-cycle offer that the transmitter
  // always takes; tx_busy high means no offer may be made. The HOLD cycle after each
  // offer hides the transmitter's one-cycle lag between we and busy rising.

  logic [LOG2_DEPTH:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH:0] rd_ptr_q, rd_ptr_d;
  drain_state_e        state_q, state_d;
  logic [WIDTH-1:0]    tx_data_q, tx_data_d;
  logic                tx_we_q, tx_we_d;
  logic                overflow_q, overflow_d;
  logic [WIDTH-1:0]    head;
  logic                wr_fire;
  logic                pop;
`ifdef RS232OUT_FIFO_CRLF_EN
  logic                crlf_sent_q, crlf_sent_d;
`endif

  // Pointer MSBs differ with equal low bits only when the FIFO has wrapped full.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[LOG2_DEPTH] != rd_ptr_q[LOG2_DEPTH]) &&
                   (wr_ptr_q[LOG2_DEPTH-1:0] == rd_ptr_q[LOG2_DEPTH-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign wr_fire = wr_en && !full;

  assign overflow  = overflow_q;
  assign tx_data   = tx_data_q;
  assign tx_we     = tx_we_q;
  assign dbg_state = state_q;

  fifo_ram #(
    .ADDR_W (LOG2_DEPTH),
    .WIDTH  (WIDTH)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (wr_fire),
    .waddr_i (wr_ptr_q[LOG2_DEPTH-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[LOG2_DEPTH-1:0]),
    .rdata_o (head)
  );

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_we_d    = 1'b0;
    pop        = 1'b0;
    overflow_d = overflow_q | (wr_en & full);
`ifdef RS232OUT_FIFO_CRLF_EN
    crlf_sent_d = crlf_sent_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!empty && !tx_busy) begin
          tx_we_d = 1'b1;
          state_d = ST_HOLD;
`ifdef RS232OUT_FIFO_CRLF_EN
          // The LF stays queued while its CR goes out, so level never counts the CR.
          if (head == ASCII_LF && !crlf_sent_q) begin
            tx_data_d   = ASCII_CR;
            crlf_sent_d = 1'b1;
          end else begin
            tx_data_d   = head;
            pop         = 1'b1;
            crlf_sent_d = 1'b0;
          end
`else
          tx_data_d = head;
          pop       = 1'b1;
`endif
        end
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + {{LOG2_DEPTH{1'b0}}, wr_fire};
    rd_ptr_d = rd_ptr_q + {{LOG2_DEPTH{1'b0}}, pop};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= ST_IDLE;
      tx_data_q  <= '0;
      tx_we_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_we_q    <= tx_we_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef RS232OUT_FIFO_CRLF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) crlf_sent_q <= 1'b0;
    else       crlf_sent_q <= crlf_sent_d;
  end
`endif

endmodule

// File: tb/tb_rs232out_fifo.sv
// Bench for rs232out_fifo: directed steps plus a random burst, checked against a
// transaction-level queue model and a behavioural transmitter (busy lags we by 1 cycle).
module tb_rs232out_fifo;
  import rs232_pkg::*;

  localparam int DEPTH = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   wr_data;
  logic         wr_en;
  logic         full;
  logic         empty;
  logic [4:0]   level;
  logic         overflow;
  logic [7:0]   tx_data;
  logic         tx_we;
  logic         tx_busy;
  drain_state_e dbg_state;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] seen_q[$];
  int         accepted;
  int         popped;
  logic       exp_ovf;
  logic       no_tx;
  logic       prev_we;
  logic       force_busy;
  int         busy_cnt = 0;

  rs232out_fifo #(.LOG2_DEPTH(4), .WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .tx_data   (tx_data),
    .tx_we     (tx_we),
    .tx_busy   (tx_busy),
    .dbg_state (dbg_state)
  );

  // Clock and transmitter model: busy rises the cycle after we and holds 1..8 cycles.
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (tx_we) busy_cnt <= int'($urandom_range(1, 8));
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  assign tx_busy = force_busy | (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mdl_level();
    return accepted - popped;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    accepted = 0;
    popped   = 0;
    exp_ovf  = 1'b0;
    prev_we  = 1'b0;
  endtask

  // Write decision uses the occupancy before the edge; a same-edge pop does not help.
  task automatic model_write(input logic [7:0] d);
    if (mdl_level() >= DEPTH) begin
      exp_ovf = 1'b1;
    end else begin
      accepted++;
`ifdef RS232OUT_FIFO_CRLF_EN
      if (d == ASCII_LF) exp_q.push_back({1'b1, ASCII_CR});
`endif
      exp_q.push_back({1'b0, d});
    end
  endtask

  task automatic sample();
    logic [8:0] e;
    if (tx_we === 1'b1) begin
      seen_q.push_back(tx_data);
      if (exp_q.size() == 0) begin
        check("tx_unexpected", 32'(tx_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(e[7:0]));
        if (!e[8]) popped++;
      end
    end
    if (no_tx) check("tx_quiet", 32'(tx_we), 32'd0);
    check("tx_we_adjacent", 32'(prev_we & tx_we), 32'd0);
    check("level", 32'(level), 32'(mdl_level()));
    check("full", 32'(full), 32'(mdl_level() == DEPTH));
    check("empty", 32'(empty), 32'(mdl_level() == 0));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    prev_we = tx_we;
  endtask

  task automatic step(input logic we, input logic [7:0] d);
    wr_en   = we;
    wr_data = d;
    if (we) model_write(d);
    @(negedge clock);
    sample();
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    reset = 1'b1;
    model_clear();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step(1'b0, 8'h00);
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
    repeat (12) step(1'b0, 8'h00);
  endtask

  task automatic wait_first_pulse(input int max_cycles);
    int n = 0;
    do begin
      step(1'b0, 8'h00);
      n++;
    end while (tx_we !== 1'b1 && n < max_cycles);
    check("first_pulse", 32'(tx_we), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    force_busy = 1'b0;
    no_tx      = 1'b0;
    model_clear();
    repeat (3) @(negedge clock);

    // Reset values.
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_we", 32'(tx_we), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    reset = 1'b0;

    // Idle after reset: no pulses.
    no_tx = 1'b1;
    repeat (20) step(1'b0, 8'h00);
    no_tx = 1'b0;

    // Back-to-back writes; first pulse one cycle after the write edge.
    step(1'b1, 8'h41);
    check("tx_we_at_write_edge", 32'(tx_we), 32'd0);
    check("empty_after_write", 32'(empty), 32'd0);
    step(1'b1, 8'h42);
    check("tx_we_latency", 32'(tx_we), 32'd1);
    check("tx_data_first", 32'(tx_data), 32'h41);
    drain(200);

    // Held off by busy, then issued on the edge after busy falls.
    force_busy = 1'b1;
    step(1'b1, 8'h55);
    no_tx = 1'b1;
    repeat (50) step(1'b0, 8'h00);
    no_tx = 1'b0;
    force_busy = 1'b0;
    step(1'b0, 8'h00);
    check("tx_we_after_busy_fall", 32'(tx_we), 32'd1);
    check("tx_data_after_busy_fall", 32'(tx_data), 32'h55);
    drain(200);

    // Line-feed handling.
    seen_q.delete();
    step(1'b1, 8'h41);
    step(1'b1, 8'h0A);
    drain(200);
    check("crlf_empty", 32'(empty), 32'd1);
`ifdef RS232OUT_FIFO_CRLF_EN
    check("crlf_count", 32'(seen_q.size()), 32'd3);
    if (seen_q.size() == 3) begin
      check("crlf_seq0", 32'(seen_q[0]), 32'h41);
      check("crlf_seq1", 32'(seen_q[1]), 32'h0D);
      check("crlf_seq2", 32'(seen_q[2]), 32'h0A);
    end
`else
    check("crlf_count", 32'(seen_q.size()), 32'd2);
    if (seen_q.size() == 2) begin
      check("crlf_seq0", 32'(seen_q[0]), 32'h41);
      check("crlf_seq1", 32'(seen_q[1]), 32'h0A);
    end
`endif

    // Fill to DEPTH, overflow on the 17th, then drain in order.
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(i));
      if (i == 15) check("full_at_16th", 32'(full), 32'd1);
    end
    check("fill_level", 32'(level), 32'd16);
    check("fill_overflow", 32'(overflow), 32'd1);
    seen_q.delete();
    force_busy = 1'b0;
    drain(1000);
`ifdef RS232OUT_FIFO_CRLF_EN
    check("fill_count", 32'(seen_q.size()), 32'd17);
`else
    check("fill_count", 32'(seen_q.size()), 32'd16);
`endif
    if (seen_q.size() != 0) begin
      check("fill_first", 32'(seen_q[0]), 32'h00);
      check("fill_last", 32'(seen_q[seen_q.size()-1]), 32'h0F);
    end
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Reset clears overflow; then randomized traffic against the model.
    do_reset();
    step(1'b0, 8'h00);
    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 9) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
      step($urandom_range(0, 99) < 55, d);
    end
    drain(3000);

    // Reset mid-operation: pulse drops at once and the queue is discarded.
    force_busy = 1'b1;
    step(1'b1, 8'hA1);
    step(1'b1, 8'hA2);
    step(1'b1, 8'hA3);
    force_busy = 1'b0;
    wait_first_pulse(20);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_tx_we", 32'(tx_we), 32'd0);
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_level", 32'(level), 32'd0);
    model_clear();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    no_tx = 1'b1;
    repeat (30) step(1'b0, 8'h00);
    no_tx = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
